// File: rtl/mppc_link_pkg.sv
// Shared definitions for the MPPC serial link scheduler: FSM encoding,
// frame geometry derivation and the frame parity helper.
package mppc_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } link_state_e;

  // Widest ID+payload the parity helper accepts; narrower words are zero-extended.
  localparam int PAR_MAX_W = 64;

  function automatic int calc_id_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  function automatic int calc_frame_bits(input int id_w, input int data_w);
    return id_w + data_w + 1;
  endfunction

  // Bit that makes the total count of ones (including itself) even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/mppc_link_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request after ptr,
// wrapping modulo N_REQ.
module rr_arbiter
  import mppc_link_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = calc_id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             valid_o
);

  logic found_s;
  logic take_s;

  // Scan offsets 1..N_REQ from the pointer; the first hit wins.
  always_comb begin
    gnt_o   = '0;
    found_s = 1'b0;
    take_s  = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      for (int j = 0; j < N_REQ; j++) begin
        take_s   = !found_s && req_i[j] && (j == ((int'(ptr_i) + off) % N_REQ));
        gnt_o[j] = gnt_o[j] | take_s;
        found_s  = found_s | take_s;
      end
    end
    valid_o = found_s;
  end

endmodule

// File: rtl/mppc_link_scheduler.sv
// Shares one clock/data serial link between N_REQ word producers; frames each
// granted word as {ID, payload, even parity} and shifts it out MSB-first.
module mppc_link_scheduler
  import mppc_link_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int BIT_DIV  = 4800,
  parameter int GAP_BITS = 2
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    EN,
  input  logic [N_REQ-1:0]        REQ,
  input  logic [N_REQ*DATA_W-1:0] REQ_DATA,
  output logic [N_REQ-1:0]        ACK,
  output logic                    clockOut,
  output logic                    dataOut,
  output logic                    frameOut
);

  localparam int ID_W       = calc_id_w(N_REQ);
  localparam int FRAME_BITS = calc_frame_bits(ID_W, DATA_W);
  localparam int DIV_W      = $clog2(BIT_DIV);
  localparam int BCNT_W     = $clog2(FRAME_BITS + 1);
  localparam int GAP_W      = (GAP_BITS > 0) ? $clog2(2 * GAP_BITS + 1) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(FRAME_BITS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(2 * GAP_BITS - 1);
  localparam logic [ID_W-1:0]   PTR_RST  = ID_W'(N_REQ - 1);

  link_state_e            state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [N_REQ-1:0]       ack_q, ack_d;
  logic                   clk_q, clk_d;
  logic                   frame_q, frame_d;

  logic [N_REQ-1:0]       arb_gnt_s;
  logic                   arb_valid_s;
  logic [ID_W-1:0]        gnt_id_s;
  logic [DATA_W-1:0]      gnt_data_s;
  logic [ID_W+DATA_W-1:0] payload_s;
  logic [FRAME_BITS-1:0]  frame_word_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i   (REQ),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt_s),
    .valid_o (arb_valid_s)
  );

  // Encode the one-hot grant and mux the granted word into a framed shift word.
  always_comb begin
    gnt_id_s   = '0;
    gnt_data_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_id_s   = gnt_id_s | (arb_gnt_s[i] ? ID_W'(i) : '0);
      gnt_data_s = gnt_data_s | ({DATA_W{arb_gnt_s[i]}} & REQ_DATA[i*DATA_W +: DATA_W]);
    end
    payload_s    = {gnt_id_s, gnt_data_s};
    frame_word_s = {payload_s, even_parity(PAR_MAX_W'(payload_s))};
  end

  // Next-state logic: grant in IDLE, bit timing in SHIFT, idle spacing in GAP.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bcnt_d  = bcnt_q;
    gap_d   = gap_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    clk_d   = clk_q;
    frame_d = frame_q;
    case (state_q)
      ST_IDLE: begin
        div_d  = '0;
        bcnt_d = '0;
        gap_d  = '0;
        clk_d  = 1'b0;
        if (EN && arb_valid_s) begin
          state_d = ST_SHIFT;
          shift_d = frame_word_s;
          ptr_d   = gnt_id_s;
          ack_d   = arb_gnt_s;
          frame_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          shift_d = '0;
          frame_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else if (!clk_q) begin
          div_d = '0;
          clk_d = 1'b1;
        end else if (bcnt_q == BIT_LAST) begin
          // Falling edge after the last bit closes the frame.
          div_d   = '0;
          bcnt_d  = '0;
          clk_d   = 1'b0;
          frame_d = 1'b0;
          shift_d = '0;
          state_d = (GAP_BITS == 0) ? ST_IDLE : ST_GAP;
        end else begin
          div_d   = '0;
          clk_d   = 1'b0;
          bcnt_d  = bcnt_q + 1'b1;
          shift_d = shift_q << 1'b1;
        end
      end
      ST_GAP: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else if (gap_q == GAP_LAST) begin
          div_d   = '0;
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          div_d = '0;
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
        bcnt_d  = '0;
        gap_d   = '0;
        shift_d = '0;
        clk_d   = 1'b0;
        frame_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bcnt_q  <= '0;
      gap_q   <= '0;
      shift_q <= '0;
      ptr_q   <= PTR_RST;
      ack_q   <= '0;
      clk_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bcnt_q  <= bcnt_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      clk_q   <= clk_d;
      frame_q <= frame_d;
    end
  end

  assign ACK      = ack_q;
  assign clockOut = clk_q;
  assign dataOut  = shift_q[FRAME_BITS-1];
  assign frameOut = frame_q;

endmodule

// File: tb/tb_mppc_link_scheduler.sv
// Directed + randomized bench for mppc_link_scheduler with a behavioural
// round-robin / framing reference model.
module tb_mppc_link_scheduler;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int BD    = 2;
  localparam int GB    = 2;
  localparam int FB    = 11;
  localparam int FLEN  = FB * 2 * BD;
  localparam int SPACE = (FB + GB) * 2 * BD + 1;

  logic            CLK = 1'b0;
  logic            RSTN;
  logic            EN;
  logic [N-1:0]    req_v, req0_v;
  logic [N-1:0][DW-1:0] wdata;
  logic [N-1:0]    ACK, ack0;
  logic            clockOut, dataOut, frameOut;
  logic            clk0, data0, frame0;

  int cyc = 0;
  int passed = 0;
  int total = 0;
  int fails = 0;
  int last_g;

  mppc_link_scheduler #(.N_REQ(N), .DATA_W(DW), .BIT_DIV(BD), .GAP_BITS(GB)) dut (
    .CLK(CLK), .RSTN(RSTN), .EN(EN), .REQ(req_v), .REQ_DATA(wdata),
    .ACK(ACK), .clockOut(clockOut), .dataOut(dataOut), .frameOut(frameOut)
  );

  mppc_link_scheduler #(.N_REQ(N), .DATA_W(DW), .BIT_DIV(BD), .GAP_BITS(0)) dut0 (
    .CLK(CLK), .RSTN(RSTN), .EN(EN), .REQ(req0_v), .REQ_DATA(wdata),
    .ACK(ack0), .clockOut(clk0), .dataOut(data0), .frameOut(frame0)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int model_grant(input logic [N-1:0] p, input int last);
    int idx;
    for (int off = 1; off <= N; off++) begin
      idx = (last + off) % N;
      if (p[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [FB-1:0] model_frame(input int id, input logic [DW-1:0] d);
    logic [FB-2:0] body;
    body = {id[1:0], d};
    return {body, 1'($countones(body) % 2)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag, output int found);
    int k;
    found = 0;
    k = 0;
    while (found == 0 && k < 400) begin
      @(negedge CLK);
      k++;
      if (ACK != 4'b0000) found = 1;
    end
    if (found == 0) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic frame_task(input string tag, input int g, input int en_drop_at,
                            input bit rearm, output int start);
    int found, len, nb, glitch, hirun;
    logic prevclk;
    logic [FB-1:0] bits, exp;
    exp = model_frame(g, wdata[g]);
    wait_ack(tag, found);
    start = cyc;
    if (found == 0) return;
    chk({tag, "_ack"}, 64'(ACK), 64'(4'b0001 << g));
    chk({tag, "_start"}, 64'({frameOut, clockOut}), 64'(2'b10));
    req_v[g] = 1'b0;
    last_g = g;
    len = 0; nb = 0; glitch = 0; hirun = 0; prevclk = 1'b0; bits = '0;
    while (frameOut === 1'b1 && len < 200) begin
      len++;
      if (clockOut && !prevclk) begin
        bits = {bits[FB-2:0], dataOut};
        nb++;
      end
      if (clockOut) hirun++;
      else if (prevclk) begin
        if (hirun != BD) glitch++;
        hirun = 0;
      end
      prevclk = clockOut;
      if (rearm && len == 2) begin
        wdata[g] = 8'($urandom);
        req_v[g] = 1'b1;
      end
      if (len == en_drop_at) EN = 1'b0;
      @(negedge CLK);
    end
    if (prevclk && hirun != BD) glitch++;
    if (clockOut || dataOut) glitch++;
    chk({tag, "_len"}, 64'(len), 64'(FLEN));
    chk({tag, "_nbits"}, 64'(nb), 64'(FB));
    chk({tag, "_bits"}, 64'(bits), 64'(exp));
    chk({tag, "_even"}, 64'($countones(bits) % 2), 64'd0);
    chk({tag, "_glitch"}, 64'(glitch), 64'd0);
  endtask

  initial begin
    int found, g, s, prev, nack, len, k;
    logic [N-1:0] nr;

    RSTN = 1'b0; EN = 1'b1; req_v = '0; req0_v = '0;
    for (int i = 0; i < N; i++) wdata[i] = 8'($urandom);
    repeat (3) @(negedge CLK);
    chk("rst_ack", 64'(ACK), 64'd0);
    chk("rst_link", 64'({clockOut, dataOut, frameOut}), 64'd0);
    chk("rst_dut0", 64'({ack0, clk0, data0, frame0}), 64'd0);
    RSTN = 1'b1;
    last_g = N - 1;

    // Asynchronous reset in the middle of a frame
    req_v = 4'b0010;
    wait_ack("rs", found);
    chk("rs_ack", 64'(ACK), 64'(4'b0010));
    req_v[1] = 1'b0;
    repeat (5) @(negedge CLK);
    #2 RSTN = 1'b0;
    #1 chk("rs_async", 64'({ACK, clockOut, dataOut, frameOut}), 64'd0);
    @(negedge CLK);
    req_v = 4'b1001; last_g = N - 1; RSTN = 1'b1;
    g = model_grant(req_v, last_g); frame_task("rs_first", g, 0, 1'b0, s);
    g = model_grant(req_v, last_g); frame_task("rs_second", g, 0, 1'b0, s);

    // Requester 2 with 0xA5
    wdata[2] = 8'hA5; req_v = 4'b0100;
    g = model_grant(req_v, last_g); frame_task("a5", g, 0, 1'b0, s);

    // All requesters continuously pending: rotation and back-to-back spacing
    @(negedge CLK); RSTN = 1'b0;
    @(negedge CLK); RSTN = 1'b1; last_g = N - 1;
    req_v = 4'b1111;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      g = model_grant(req_v, last_g);
      frame_task("rr", g, 0, 1'b1, s);
      if (i > 0) chk("rr_space", 64'(s - prev), 64'(SPACE));
      prev = s;
    end
    req_v = '0;

    // EN dropped mid-frame
    req_v = 4'b0010;
    g = model_grant(req_v, last_g); frame_task("en", g, FLEN / 2, 1'b0, s);
    req_v = 4'b0101;
    nack = 0;
    repeat (60) begin
      @(negedge CLK);
      if (ACK != 4'b0000) nack++;
    end
    chk("en_noack", 64'(nack), 64'd0);
    EN = 1'b1;
    g = model_grant(req_v, last_g); frame_task("en_resume", g, 0, 1'b0, s);
    g = model_grant(req_v, last_g); frame_task("en_rest", g, 0, 1'b0, s);

    // Requester 3 with all-zero and all-one payloads
    wdata[3] = 8'h00; req_v = 4'b1000;
    g = model_grant(req_v, last_g); frame_task("z00", g, 0, 1'b0, s);
    wdata[3] = 8'hFF; req_v = 4'b1000;
    g = model_grant(req_v, last_g); frame_task("zff", g, 0, 1'b0, s);

    // Randomized request mixes
    for (int r = 0; r < 6; r++) begin
      nr = 4'($urandom);
      if ((req_v | nr) == 4'b0000) nr = 4'b0001;
      for (int i = 0; i < N; i++)
        if (nr[i] && !req_v[i]) wdata[i] = 8'($urandom);
      req_v = req_v | nr;
      g = model_grant(req_v, last_g);
      frame_task("rnd", g, 0, 1'b0, s);
    end
    req_v = '0;
    repeat (20) @(negedge CLK);

    // Zero-gap instance with requester 0 held high
    wdata[0] = 8'($urandom);
    req0_v = 4'b0001;
    found = 0; k = 0;
    while (found == 0 && k < 400) begin
      @(negedge CLK);
      k++;
      if (ack0 != 4'b0000) found = 1;
    end
    chk("g0_first_ack", 64'(ack0), 64'(4'b0001));
    for (int f = 0; f < 2; f++) begin
      len = 0;
      while (frame0 === 1'b1 && len < 200) begin
        len++;
        @(negedge CLK);
      end
      chk("g0_len", 64'(len), 64'(FLEN));
      chk("g0_fall", 64'({ack0, clk0, data0}), 64'd0);
      @(negedge CLK);
      chk("g0_ack", 64'({ack0, frame0, clk0}), 64'({4'b0001, 1'b1, 1'b0}));
    end
    req0_v = '0;
    repeat (60) @(negedge CLK);
    chk("g0_idle", 64'({clk0, frame0}), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
